// File: rtl/dmem_responder_if.sv
// Load/store request bus between the CPU (master) and the data-memory responder (slave).
// Handshake: master holds req_i with stable fields until it sees ack_o, then drops req_i the cycle after.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  rdata_o, ack_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output rdata_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LATENCY edges in total,
// performs the access on the internal word array and pulses ack_o (qualified by err_o).
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus,
    output logic [1:0]        dbg_state
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic        enter_resp;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_bad;
    logic [AW-1:0] acc_idx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, so the live bus fields are used.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = bus.we_i;
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
            acc_be    = bus.be_i;
        end
        acc_bad = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_LIM);
        acc_idx = acc_addr[AW+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= enter_resp && acc_bad;
            if (capture) begin
                we_q    <= bus.we_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
                be_q    <= bus.be_i;
            end
            // Stores leave rdata untouched so the last load result stays visible.
            if (enter_resp && acc_bad) begin
                rdata_q <= 32'd0;
            end else if (enter_resp && !acc_we) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // The array is deliberately not reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp && acc_we && !acc_bad) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) begin
                    mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = (state_q == RESP);
    assign bus.err_o   = err_q;
    assign bus.busy_o  = (state_q == WAIT) || (state_q == RESP);
    assign dbg_state   = state_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far end of the CPU's load/store request interface.
- The CPU raises a request; this block accepts it, waits a fixed latency, then performs the read or write against an internal word array.
- It answers with a one-cycle acknowledge, and optionally an error flag.
- Replaces zero-latency data memory so stall logic in the pipeline can be exercised.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; legal word index is 0..DEPTH_WORDS-1.
- LATENCY, 4: cycles from request acceptance to ack_o; legal range 1..15.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  synchronous reset, active-low (0 = reset), sampled on clk_i rising edge.
- req_i  input  1  request valid; initiator holds it high with stable fields until ack_o.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data.
- be_i  input  4  byte enables for stores; be_i[n] covers wdata_i[8n+7:8n]; ignored for loads.
- rdata_o  output  32  load data, valid when ack_o=1 and we was 0.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  qualifies ack_o; 1 = misaligned or out-of-range access.
- busy_o  output  1  1 while a request is held internally (WAIT or RESP).

Behaviour:
- Reset (rst_i=0 at an edge):
  - state=IDLE, ack_o=0, err_o=0, busy_o=0, rdata_o=0, latency counter=0.
  - Array contents are not cleared.
- Reset mid-operation:
  - The in-flight transaction is dropped. No array write and no ack.
  - Nothing is taken from req_i on that edge.
- IDLE:
  - On an edge with req_i=1, latch we_i, addr_i, wdata_i, be_i.
  - If LATENCY=1, go to RESP; otherwise load counter with LATENCY-2 and go to WAIT.
  - busy_o=1 from the next cycle.
- WAIT:
  - Decrement the counter each edge; go to RESP on the edge where it is 0.
  - req_i and the fields are ignored in this state.
- Transition into RESP: the access is performed on that edge, using the latched fields.
  - Error check: latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS sets err_o=1 and rdata_o=0. No array access.
  - Load: rdata_o = array[addr[31:2]].
  - Store: for each n with be[n]=1, write byte n. rdata_o keeps its previous value.
  - ack_o=1 is asserted in this cycle.
- Latency: request accepted at edge T gives ack_o high during the cycle after edge T+LATENCY-1, i.e. LATENCY edges after acceptance.
- RESP:
  - Lasts exactly one cycle.
  - Next edge: ack_o=0, err_o=0, busy_o=0, back to IDLE.
  - req_i is not sampled on that edge.
- Throughput: at most one transaction per LATENCY+1 cycles.
  - The initiator drops req_i in the cycle after ack_o.
  - A req_i still high in IDLE is taken as a new request.
- Read data hold: rdata_o holds its value until the next load or error ack.
- Ordering: a store followed by a load to the same word returns the stored bytes merged with the old unenabled bytes.
- be_i=4'b0000 on a store: no bytes change; ack still issued with err_o=0.
- Word index arithmetic: addr[31:2] compared unsigned against DEPTH_WORDS; no wrap-around.

Test Plan:
- Reset with rst_i=0 for 2 cycles, then release -> ack_o=0, busy_o=0, rdata_o=0x00000000, state IDLE.
- LATENCY=4, store addr=0x10 wdata=0xDEADBEEF be=4'hF at edge T, drop req after ack, then load 0x10 -> first ack exactly 4 edges after T with err_o=0; load returns 0xDEADBEEF; busy_o high for 4 cycles each.
- Store 0x10 wdata=0x11223344 be=4'b0101 over 0xDEADBEEF, then load 0x10 -> rdata_o=0xDE22BE44.
- Misaligned load 0x13, and load at byte address 4*DEPTH_WORDS (0x1000 for default) -> ack with err_o=1, rdata_o=0; array unchanged on re-read of 0x10.
- Store 0x20 accepted, rst_i=0 two edges later, then release and load 0x20 -> no ack for the dropped store; load returns the pre-store contents.
- LATENCY=1, req_i held high continuously with loads -> ack_o on alternate cycles, busy_o alternating 1/0, one transaction per 2 cycles.
